// File: rtl/cdc_handshake_rx_if.sv
// Bundle of the four-phase crossing signals and the local valid/ready stream.
//   reqAsync  : request from the source domain (asynchronous to the local clock)
//   dataAsync : quasi-static data, stable while reqAsync=1 and until ackOut=1
//   ackOut    : acknowledge back to the source domain
//   dataOut   : captured word presented locally
//   valid     : dataOut holds an unconsumed word
//   ready     : local consumer accepts dataOut when valid=1
// Modports: slave = receive controller, master = source/consumer side.
interface cdc_handshake_rx_if #(
  parameter int unsigned LEN = 32
);
  logic           reqAsync;
  logic [LEN-1:0] dataAsync;
  logic           ackOut;
  logic [LEN-1:0] dataOut;
  logic           valid;
  logic           ready;

  modport slave (
    input  reqAsync,
    input  dataAsync,
    input  ready,
    output ackOut,
    output dataOut,
    output valid
  );

  modport master (
    output reqAsync,
    output dataAsync,
    output ready,
    input  ackOut,
    input  dataOut,
    input  valid
  );
endinterface

// File: rtl/cdc_handshake_rx.sv
// Receive-side controller for a four-phase req/ack multi-bit clock-domain crossing.
// Only the request bit is synchronized (STAGES-deep flop chain); the data bus is
// captured once the synchronized request is seen, presented on a local
// valid/ready interface, and acknowledged back to the source domain.
//
// Ports:
//   clk   : local clock, all logic on rising edge
//   rst_n : synchronous active-low reset
//   bus   : cdc_handshake_rx_if.slave (reqAsync, dataAsync, ready in;
//           ackOut, dataOut, valid out)
//
// Parameters:
//   LEN    : width of the crossed data bus
//   STAGES : depth of the request synchronizer chain (must be >= 2)
//
// Build option CDC_RX_EARLY_ACK_EN: acknowledge on the capture edge instead of
// after consumption; valid is then tracked independently of the handshake state.
module cdc_handshake_rx #(
  parameter int unsigned LEN    = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cdc_handshake_rx_if.slave    bus
);

`ifdef CDC_RX_EARLY_ACK_EN
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [STAGES-1:0] sync_q;
  logic             req_sync;
  logic             ack_q, ack_d;
  logic             valid_q, valid_d;
  logic [LEN-1:0]   data_q, data_d;

  // Request synchronizer: the only path from reqAsync into local logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], bus.reqAsync};
    end
  end

  assign req_sync = sync_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`ifdef CDC_RX_EARLY_ACK_EN
  logic consume;

  // ackOut is low only in IDLE, so a capture there always starts a new transfer.
  // A pending word may be replaced on the same edge it is consumed.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    consume = valid_q & bus.ready;

    if (consume) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (req_sync && !ack_q && (!valid_q || consume)) begin
          data_d  = bus.dataAsync;
          valid_d = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_sync) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
`else
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;

    unique case (state_q)
      IDLE: begin
        if (req_sync) begin
          data_d  = bus.dataAsync;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      // A request dropped early by the source is ignored here; the word is
      // still delivered and ACK then exits on its first edge.
      HOLD: begin
        if (valid_q && bus.ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_sync) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
`endif

  assign bus.ackOut  = ack_q;
  assign bus.valid   = valid_q;
  assign bus.dataOut = data_q;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Directed self-checking bench for cdc_handshake_rx (LEN=32, STAGES=2).
// Builds with or without CDC_RX_EARLY_ACK_EN; tests specific to one build are
// selected by the same macro.
module tb_cdc_handshake_rx;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  cdc_handshake_rx_if #(.LEN(32)) bus ();

  cdc_handshake_rx #(
    .LEN   (32),
    .STAGES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return the DUT to IDLE with nothing pending (no checks).
  task automatic drain();
    bus.reqAsync = 1'b0;
    bus.ready    = 1'b1;
    repeat (10) tick();
    bus.ready    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.reqAsync  = 1'b1;
    bus.dataAsync = 32'hDEADBEEF;
    bus.ready     = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.ackOut !== 1'b0) begin
      errors++; $display("FAIL reset_ack: got %b expected 0", bus.ackOut);
    end
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid);
    end
    checks++;
    if (bus.dataOut !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 00000000", bus.dataOut);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (bus.valid !== (i == 3)) begin
        errors++; $display("FAIL reset_release_valid edge %0d: got %b expected %b", i, bus.valid, (i == 3));
      end
    end
    checks++;
    if (bus.dataOut !== 32'hDEADBEEF) begin
      errors++; $display("FAIL reset_release_data: got %h expected deadbeef", bus.dataOut);
    end
    drain();
  endtask

`ifndef CDC_RX_EARLY_ACK_EN
  task automatic test_basic();
    bus.ready     = 1'b1;
    bus.dataAsync = 32'h12345678;
    bus.reqAsync  = 1'b1;
    tick(); tick();
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++; $display("FAIL basic_pre_valid: got %b expected 0", bus.valid);
    end
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.ackOut !== 1'b0) begin
      errors++; $display("FAIL basic_capture: valid=%b ack=%b expected valid=1 ack=0", bus.valid, bus.ackOut);
    end
    checks++;
    if (bus.dataOut !== 32'h12345678) begin
      errors++; $display("FAIL basic_data: got %h expected 12345678", bus.dataOut);
    end
    tick();
    checks++;
    if (bus.valid !== 1'b0 || bus.ackOut !== 1'b1) begin
      errors++; $display("FAIL basic_ack: valid=%b ack=%b expected valid=0 ack=1", bus.valid, bus.ackOut);
    end
    bus.reqAsync = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (bus.ackOut !== (i < 3)) begin
        errors++; $display("FAIL basic_ack_drop edge %0d: got %b expected %b", i, bus.ackOut, (i < 3));
      end
    end
    checks++;
    if (bus.dataOut !== 32'h12345678) begin
      errors++; $display("FAIL basic_data_kept: got %h expected 12345678", bus.dataOut);
    end
    drain();
  endtask

  task automatic test_backpressure();
    bus.ready     = 1'b0;
    bus.dataAsync = 32'hA5A50F0F;
    bus.reqAsync  = 1'b1;
    repeat (3) tick();
    bus.dataAsync = 32'h0;   // source data is not re-sampled after capture
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.valid !== 1'b1 || bus.ackOut !== 1'b0 || bus.dataOut !== 32'hA5A50F0F) begin
        errors++;
        $display("FAIL backpressure cycle %0d: valid=%b ack=%b data=%h expected 1 0 a5a50f0f",
                 i, bus.valid, bus.ackOut, bus.dataOut);
      end
    end
    bus.ready = 1'b1;
    tick();
    checks++;
    if (bus.valid !== 1'b0 || bus.ackOut !== 1'b1) begin
      errors++; $display("FAIL backpressure_release: valid=%b ack=%b expected 0 1", bus.valid, bus.ackOut);
    end
    drain();
  endtask

  task automatic test_reset_in_hold();
    int deliveries;
    bus.ready     = 1'b0;
    bus.dataAsync = 32'hCAFEF00D;
    bus.reqAsync  = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.valid !== 1'b0 || bus.ackOut !== 1'b0 || bus.dataOut !== 32'h0) begin
      errors++; $display("FAIL hold_reset: valid=%b ack=%b data=%h expected 0 0 00000000",
                         bus.valid, bus.ackOut, bus.dataOut);
    end
    repeat (3) tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.dataOut !== 32'hCAFEF00D) begin
      errors++; $display("FAIL hold_recapture: valid=%b data=%h expected 1 cafef00d", bus.valid, bus.dataOut);
    end
    bus.ready  = 1'b1;
    deliveries = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.valid && bus.ready) deliveries++;
      tick();
      if (bus.ackOut) bus.reqAsync = 1'b0;
    end
    checks++;
    if (deliveries !== 1) begin
      errors++; $display("FAIL hold_redeliver_count: got %0d expected 1", deliveries);
    end
    drain();
  endtask
`else
  task automatic test_early_ack();
    bus.ready     = 1'b0;
    bus.dataAsync = 32'h11111111;
    bus.reqAsync  = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.ackOut !== 1'b1) begin
      errors++; $display("FAIL early_capture: valid=%b ack=%b expected 1 1", bus.valid, bus.ackOut);
    end
    bus.reqAsync = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.ackOut !== 1'b0 || bus.valid !== 1'b1) begin
      errors++; $display("FAIL early_ack_drop: ack=%b valid=%b expected 0 1", bus.ackOut, bus.valid);
    end
    bus.dataAsync = 32'h22222222;
    bus.reqAsync  = 1'b1;
    repeat (5) tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.ackOut !== 1'b0 || bus.dataOut !== 32'h11111111) begin
      errors++; $display("FAIL early_blocked: valid=%b ack=%b data=%h expected 1 0 11111111",
                         bus.valid, bus.ackOut, bus.dataOut);
    end
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    checks++;
    if (bus.valid !== 1'b1 || bus.ackOut !== 1'b1 || bus.dataOut !== 32'h22222222) begin
      errors++; $display("FAIL early_swap: valid=%b ack=%b data=%h expected 1 1 22222222",
                         bus.valid, bus.ackOut, bus.dataOut);
    end
    drain();
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] rx[$];
    logic [15:0] pat;
    int          src_idx;
    bit          phase;
    int          cyc;
    pat           = 16'b0110_1011_0010_1101;
    src_idx       = 0;
    phase         = 1'b0;
    cyc           = 0;
    bus.ready     = 1'b0;
    bus.dataAsync = 32'd1;
    bus.reqAsync  = 1'b1;
    while (src_idx < 4 && cyc < 400) begin
      @(negedge clk);
      if (bus.valid && bus.ready) rx.push_back(bus.dataOut);
      tick();
      if (!phase && bus.ackOut) begin
        bus.reqAsync = 1'b0;
        phase        = 1'b1;
      end else if (phase && !bus.ackOut) begin
        src_idx++;
        phase = 1'b0;
        if (src_idx < 4) begin
          bus.dataAsync = 32'(src_idx + 1);
          bus.reqAsync  = 1'b1;
        end
      end
      bus.ready = pat[cyc % 16];
      cyc++;
    end
    checks++;
    if (src_idx != 4) begin
      errors++; $display("FAIL b2b_timeout: source finished %0d of 4 words", src_idx);
    end
    // Let any still-pending word drain out before counting.
    bus.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.valid && bus.ready) rx.push_back(bus.dataOut);
      tick();
    end
    checks++;
    if (rx.size() != 4) begin
      errors++; $display("FAIL b2b_count: got %0d words expected 4", rx.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rx.size() || rx[i] !== 32'(i + 1)) begin
        errors++;
        $display("FAIL b2b_word %0d: got %h expected %h", i, (i < rx.size()) ? rx[i] : 32'hx, 32'(i + 1));
      end
    end
    drain();
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.reqAsync  = 1'b0;
    bus.dataAsync = '0;
    bus.ready     = 1'b0;
    test_reset();
`ifndef CDC_RX_EARLY_ACK_EN
    test_basic();
    test_backpressure();
    test_reset_in_hold();
`else
    test_early_ack();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
